hack_ram_dumper: RTL and testbench
==================================

# hack_ram_dumper

Post-run result reader for the Hack CPU system: watches the program counter, detects the terminal infinite loop that ends every Hack program, then freezes the CPU and streams a fixed window of data RAM out over a valid/ready port. It sits beside `top`, sharing the data-RAM port through a select line. The bench and a future host link can collect results this way instead of peeking into the memory array hierarchically.

## Interface
- ADDR_W, 15: RAM and PC address width.
- DATA_W, 16: RAM word width.
- DUMP_BASE, 0: first RAM address dumped.
- DUMP_LEN, 16: number of words dumped; must be ≥1.
- HALT_CNT, 8: consecutive loop-match cycles required to declare halt; must be ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse that starts monitoring; honoured only in IDLE or DONE.
- pc  in  ADDR_W  CPU program counter.
- cpu_hold  out  1  holds the CPU in reset while high.
- ram_sel  out  1  gives the dumper ownership of the RAM address mux when high.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rdata  in  DATA_W  RAM read data.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  sink accepts the word.
- dout_data  out  DATA_W  dumped word.
- dout_addr  out  ADDR_W  RAM address of dout_data; 0 on the checksum word.
- dout_last  out  1  marks the final word of the dump.
- busy  out  1  high in WATCH, READ and SEND.
- done  out  1  high in DONE.

## Operation
- States are IDLE, WATCH, READ, SEND and DONE.
- **IDLE**
  - arm moves to WATCH.
  - All outputs are 0.
- **WATCH**
  - The block keeps pc history pc_d1 and pc_d2; both are marked invalid on entry.
  - Halt counter: each cycle with valid history and pc==pc_d2, it increments; otherwise it clears.
  - This match catches both the two-instruction loop (@END / 0;JMP) and a single-instruction self-jump.
  - When the counter reaches HALT_CNT, the block moves to READ with the word index reset to 0.
- **READ**
  - cpu_hold=1, ram_sel=1, ram_addr=DUMP_BASE+index (modulo 2^ADDR_W).
  - Next cycle: ram_rdata is captured into dout_data, dout_addr takes ram_addr, and the block moves to SEND.
  - Capturing one cycle later works with either combinational or registered RAM reads.
- **SEND**
  - dout_valid=1.
  - dout_data, dout_addr and dout_last stay stable until dout_ready is high.
  - On transfer with more words remaining: index increments and the block returns to READ.
  - On transfer of the final word: the block moves to DONE.
- **DONE**
  - done=1, cpu_hold=1, ram_sel=0, dout_valid=0.
  - arm clears done, releases cpu_hold and moves to WATCH.
- arm is ignored in WATCH, READ and SEND.
- cpu_hold and ram_sel stay high from READ entry until DONE; cpu_hold alone persists in DONE.

## Timing
- Every output resets to 0.
- Asynchronous reset at any point, including mid-SEND, returns the block to IDLE and drops dout_valid immediately.
- Halt is declared at the earliest HALT_CNT+2 cycles after WATCH entry.
- The first dout_valid rises 2 cycles after halt is declared: one cycle in READ, one for the capture.
- Maximum throughput is one word per 2 cycles (READ, then SEND with dout_ready held high).
- With dout_ready low, SEND holds indefinitely and the words presented on the port are unchanged.
- dout_last is high only on the final word.
- Address wraps: with DUMP_BASE=2^ADDR_W−1, the next address is 0.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - After the last RAM word, one extra SEND cycle carries the DATA_W-bit wraparound sum of all dumped words, with dout_addr=0.
  - dout_last is on the checksum word only.
- DUMP_CHECKSUM_EN undefined:
  - No checksum word is sent.
  - dout_last is on the last RAM word.

## Structure
- The shared package hack_dbg_pkg holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - the HALT_CNT counter width function.
- One sub-module, hack_halt_detect, contains the pc history, the match logic and the saturating counter, and outputs a one-cycle halt pulse.

## Test plan
- RAM[0]=2, RAM[1]=3, add program writes RAM[2]; DUMP_BASE=0, DUMP_LEN=3, arm -> words 2, 3, 5 at addresses 0, 1, 2, last on 5. With DUMP_CHECKSUM_EN: a fourth word 10 carries last.
- Same run with RAM[0]=566, RAM[1]=3, dout_ready toggled every 3 cycles -> 566, 3, 569, each held stable while ready is low, no words lost or duplicated.
- pc incrementing and never looping for 1000 cycles -> remains in WATCH; cpu_hold=0 and dout_valid=0 throughout.
- DUMP_BASE=0x7FFF, DUMP_LEN=2 -> dout_addr sequence 0x7FFF, 0x0000.
- rst_n pulled low during the second SEND -> all outputs 0 asynchronously; after release the block is in IDLE and a fresh arm gives a full dump.
- arm pulsed during SEND -> ignored. arm in DONE -> done=0, cpu_hold=0, and a second dump follows.

Source files
------------

// File: rtl/hack_dbg_pkg.sv
// Shared types and helpers for the Hack debug/dump blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hack_dbg_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WATCH = 3'd1,
        ST_READ  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_t;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int halt_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hack_ram_dumper_if.sv
// Dump output stream: one RAM word (or checksum) per transfer with its address and a last marker.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready; the master holds data/addr/last while valid is high and ready is low.
interface hack_ram_dumper_if
    import hack_dbg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic [ADDR_W-1:0] dout_addr;
    logic              dout_last;

    modport master (
        output dout_valid,
        output dout_data,
        output dout_addr,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_data,
        input  dout_addr,
        input  dout_last,
        output dout_ready
    );

endinterface

// File: rtl/hack_halt_detect.sv
// Detects the Hack terminal loop: pc equal to the pc two cycles back for HALT_CNT consecutive cycles.
// Latency: halt pulse at the earliest HALT_CNT+2 cycles after en rises (two cycles to fill the history).
// Backpressure: none; en low clears history and counter so every enable starts fresh.
module hack_halt_detect
    import hack_dbg_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HALT_CNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt
);

    localparam int            CW      = halt_cnt_w(HALT_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(HALT_CNT);

    logic [ADDR_W-1:0] pc_d1;
    logic [ADDR_W-1:0] pc_d2;
    logic              v1;
    logic              v2;
    logic [CW-1:0]     cnt;
    logic              fired;
    logic              match;

    // Comparing against two cycles back covers both the @END/0;JMP pair and a self-jump.
    assign match = v2 && (pc == pc_d2);
    assign halt  = en && (cnt == CNT_MAX) && !fired;

    // PC history with validity flags and the saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_d1 <= '0;
            pc_d2 <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            cnt   <= '0;
            fired <= 1'b0;
        end else if (!en) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            cnt   <= '0;
            fired <= 1'b0;
        end else begin
            pc_d1 <= pc;
            pc_d2 <= pc_d1;
            v1    <= 1'b1;
            v2    <= v1;
            fired <= fired | halt;
            if (!match) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hack_ram_dumper.sv
// Post-run RAM dumper: spots the Hack end-of-program loop, freezes the CPU, streams a RAM window out.
// Latency: halt >= HALT_CNT+2 cycles after arm, first word 2 cycles later, then at most 1 word per 2 cycles.
// Backpressure: SEND holds data/addr/last until dout_ready; no buffering. Option DUMP_CHECKSUM_EN adds a sum word.
module hack_ram_dumper
    import hack_dbg_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int unsigned DUMP_BASE = 0,
    parameter int          DUMP_LEN  = 16,
    parameter int          HALT_CNT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_hold,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    hack_ram_dumper_if.master dout
);

    localparam int                IW       = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [IW-1:0]     IDX_LAST = IW'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);

    dump_state_t       state_q;
    dump_state_t       state_d;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic              halt;
    logic              watch_en;
    logic              final_word;
    logic              last_ram_word;

    assign last_ram_word = (idx_q == IDX_LAST);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              csum_q;
    assign final_word = csum_q;
`else
    assign final_word = last_ram_word;
`endif

    assign watch_en = (state_q == ST_WATCH);

    hack_halt_detect #(
        .ADDR_W   (ADDR_W),
        .HALT_CNT (HALT_CNT)
    ) u_halt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (watch_en),
        .pc    (pc),
        .halt  (halt)
    );

    // State register; async reset drops every state-decoded output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs; arm only counts in IDLE and DONE.
    always_comb begin
        state_d         = state_q;
        cpu_hold        = 1'b0;
        ram_sel         = 1'b0;
        ram_addr        = '0;
        busy            = 1'b0;
        done            = 1'b0;
        dout.dout_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_WATCH;
            end
            ST_WATCH: begin
                busy = 1'b1;
                if (halt) state_d = ST_READ;
            end
            ST_READ: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                ram_sel  = 1'b1;
                ram_addr = BASE + ADDR_W'(idx_q);
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                busy            = 1'b1;
                cpu_hold        = 1'b1;
                ram_sel         = 1'b1;
                ram_addr        = BASE + ADDR_W'(idx_q);
                dout.dout_valid = 1'b1;
                if (dout.dout_ready) begin
                    if (final_word) begin
                        state_d = ST_DONE;
`ifdef DUMP_CHECKSUM_EN
                    end else if (last_ram_word) begin
                        state_d = ST_SEND;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                if (arm) state_d = ST_WATCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word index and output holding registers; loaded in READ, advanced on a SEND transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q  <= '0;
            csum_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_WATCH: begin
                    idx_q <= '0;
`ifdef DUMP_CHECKSUM_EN
                    sum_q  <= '0;
                    csum_q <= 1'b0;
`endif
                end
                ST_READ: begin
                    data_q <= ram_rdata;
                    addr_q <= ram_addr;
`ifdef DUMP_CHECKSUM_EN
                    last_q <= 1'b0;
                    sum_q  <= sum_q + ram_rdata;
`else
                    last_q <= last_ram_word;
`endif
                end
                ST_SEND: begin
                    if (dout.dout_ready && !final_word) begin
`ifdef DUMP_CHECKSUM_EN
                        if (last_ram_word) begin
                            data_q <= sum_q;
                            addr_q <= '0;
                            last_q <= 1'b1;
                            csum_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
`else
                        idx_q <= idx_q + IW'(1);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout.dout_data = data_q;
    assign dout.dout_addr = addr_q;
    assign dout.dout_last = last_q;

endmodule

// File: tb/tb_hack_ram_dumper.sv
// Randomized bench for hack_ram_dumper: two instances (base 0 / len 3, base 0x7FFF / len 2).
// Latency: expected first-word cycle derived from the driven pc sequence.
// Backpressure: dout_ready driven constant, toggled every 3 cycles, or random.
module tb_hack_ram_dumper;
    import hack_dbg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        ready;
    logic        sel;
    logic [14:0] pc;
    logic        arm_a, arm_b;
    logic [15:0] mem [0:32767];

    logic        hold_a, rsel_a, busy_a, done_a;
    logic [14:0] raddr_a;
    logic [15:0] rdata_a;
    logic        hold_b, rsel_b, busy_b, done_b;
    logic [14:0] raddr_b;
    logic [15:0] rdata_b;

    logic        m_valid, m_last, m_hold, m_sel, m_busy, m_done;
    logic [15:0] m_data;
    logic [14:0] m_addr, m_raddr;

    int n_chk;
    int n_err;

    hack_ram_dumper_if #(.ADDR_W(15), .DATA_W(16)) if_a ();
    hack_ram_dumper_if #(.ADDR_W(15), .DATA_W(16)) if_b ();

    assign arm_a = arm & ~sel;
    assign arm_b = arm & sel;
    assign if_a.dout_ready = ready;
    assign if_b.dout_ready = ready;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    hack_ram_dumper #(.ADDR_W(15), .DATA_W(16), .DUMP_BASE(0), .DUMP_LEN(3), .HALT_CNT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .arm(arm_a), .pc(pc), .cpu_hold(hold_a), .ram_sel(rsel_a),
        .ram_addr(raddr_a), .ram_rdata(rdata_a), .busy(busy_a), .done(done_a), .dout(if_a)
    );

    hack_ram_dumper #(.ADDR_W(15), .DATA_W(16), .DUMP_BASE(32'h7FFF), .DUMP_LEN(2), .HALT_CNT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(arm_b), .pc(pc), .cpu_hold(hold_b), .ram_sel(rsel_b),
        .ram_addr(raddr_b), .ram_rdata(rdata_b), .busy(busy_b), .done(done_b), .dout(if_b)
    );

    // Observe whichever instance the current test is exercising.
    always_comb begin
        m_valid = sel ? if_b.dout_valid : if_a.dout_valid;
        m_data  = sel ? if_b.dout_data  : if_a.dout_data;
        m_addr  = sel ? if_b.dout_addr  : if_a.dout_addr;
        m_last  = sel ? if_b.dout_last  : if_a.dout_last;
        m_hold  = sel ? hold_b  : hold_a;
        m_sel   = sel ? rsel_b  : rsel_a;
        m_raddr = sel ? raddr_b : raddr_a;
        m_busy  = sel ? busy_b  : busy_a;
        m_done  = sel ? done_b  : done_a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {m_valid, m_last, m_hold, m_sel, m_busy, m_done}, 6'd0);
        chk({tag, "_data"}, m_data, 16'd0);
        chk({tag, "_addr"}, {m_addr, m_raddr}, 30'd0);
    endtask

    // PC seen by the dumper k cycles after arm: a straight run, then a 1- or 2-instruction loop.
    function automatic logic [14:0] pc_at(input int k, input int pre, input logic [14:0] start,
                                          input bit two, input logic [14:0] lpc);
        if (k < pre) return start + 15'(k);
        if (two && ((k - pre) % 2 == 1)) return lpc + 15'd1;
        return lpc;
    endfunction

    task automatic do_dump(input bit sb, input int hc, input int len, input logic [14:0] base,
                           input int rmode, input bit arm_send, input int rst_word,
                           input int pre, input bit two, input logic [14:0] lpc);
        logic [15:0] eq_d[$];
        logic [14:0] eq_a[$];
        bit          eq_l[$];
        logic [15:0] sum;
        logic [14:0] a;
        logic [14:0] start;
        logic [15:0] hd;
        logic [14:0] ha;
        int          khalt, run, got;
        bit          seen_valid, held;

        // Reference: the window of RAM words in address order, last flag on the final word.
        start = 15'($urandom_range(100, 20000));
        sum = '0;
        for (int i = 0; i < len; i++) begin
            a = base + 15'(i);
            eq_d.push_back(mem[a]);
            eq_a.push_back(a);
            eq_l.push_back(1'b0);
            sum = sum + mem[a];
        end
`ifdef DUMP_CHECKSUM_EN
        eq_d.push_back(sum);
        eq_a.push_back(15'd0);
        eq_l.push_back(1'b0);
`endif
        eq_l[eq_l.size() - 1] = 1'b1;

        // Reference: first cycle where hc consecutive pc==pc(two back) matches have been seen.
        khalt = -1;
        run = 0;
        for (int k = 2; k < 400 && khalt < 0; k++) begin
            run = (pc_at(k, pre, start, two, lpc) == pc_at(k - 2, pre, start, two, lpc)) ? run + 1 : 0;
            if (run == hc) khalt = k;
        end

        @(negedge clk);
        sel = sb;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        got = 0;
        held = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < 600 && got < eq_d.size(); k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                chk("arm_busy", m_busy, 1'b1);
                chk("arm_done_hold", {m_done, m_hold}, 2'b00);
            end
            if (k == khalt + 1) chk("prehalt_hold", {m_hold, m_sel, m_valid}, 3'b000);
            if (k == khalt + 2) begin
                chk("read_ctl", {m_hold, m_sel, m_valid}, 3'b110);
                chk("read_addr", m_raddr, base);
            end
            if (m_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("first_valid_cyc", k, khalt + 3);
            end
            if (held) begin
                chk("stable_valid", m_valid, 1'b1);
                chk("stable_data", m_data, hd);
                chk("stable_addr", m_addr, ha);
            end
            if (m_valid) chk("send_hold_sel", {m_hold, m_sel}, 2'b11);
            if (m_valid && got == rst_word) begin
                arm = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                return;
            end
            pc = pc_at(k, pre, start, two, lpc);
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ((k / 3) % 2 == 1);
                default: ready = 1'(($urandom_range(0, 1)));
            endcase
            arm = (arm_send && m_valid && got == 1);
            if (m_valid && ready) begin
                chk("word_data", m_data, eq_d[got]);
                chk("word_addr", m_addr, eq_a[got]);
                chk("word_last", m_last, eq_l[got]);
                got++;
                held = 1'b0;
            end else if (m_valid) begin
                held = 1'b1;
                hd = m_data;
                ha = m_addr;
            end
        end
        arm = 1'b0;
        if (got < eq_d.size()) chk("dump_timeout", got, eq_d.size());
        @(negedge clk);
        chk("done_state", {m_done, m_hold, m_sel, m_valid, m_busy}, 5'b11000);
    endtask

    task automatic rand_loop_dump(input bit sb, input int hc, input int len, input logic [14:0] base,
                                  input int rmode, input bit arm_send, input int rst_word);
        do_dump(sb, hc, len, base, rmode, arm_send, rst_word, $urandom_range(0, 20),
                1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)));
    endtask

    initial begin
        int bad;
        logic [14:0] s;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        arm = 1'b0;
        ready = 1'b0;
        sel = 1'b0;
        pc = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_a");
        sel = 1'b1;
        #1 chk_all_zero("reset_b");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_a");

        // Add program result: 2 + 3 -> RAM[2]; ready held high, self-jump loop.
        mem[0] = 16'd2;
        mem[1] = 16'd3;
        mem[2] = 16'd5;
        do_dump(1'b0, 8, 3, 15'd0, 0, 1'b0, -1, 5, 1'b0, 15'd40);

        // Re-arm from DONE: 566 + 3, ready toggles every 3 cycles, arm pulsed during SEND.
        mem[0] = 16'd566;
        mem[2] = 16'd569;
        do_dump(1'b0, 8, 3, 15'd0, 1, 1'b1, -1, 3, 1'b1, 15'd100);

        // Reset during the second SEND, then a full dump from IDLE.
        for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
        rand_loop_dump(1'b0, 8, 3, 15'd0, 2, 1'b0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {m_busy, m_done, m_hold, m_valid}, 4'b0000);
        rand_loop_dump(1'b0, 8, 3, 15'd0, 2, 1'b0, -1);

        // Address wrap at the top of RAM.
        mem[15'h7FFF] = 16'($urandom);
        mem[0] = 16'($urandom);
        rand_loop_dump(1'b1, 3, 2, 15'h7FFF, 2, 1'b0, -1);

        // Randomized repeats on both instances.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
            mem[15'h7FFF] = 16'($urandom);
            rand_loop_dump(1'b0, 8, 3, 15'd0, 2, 1'($urandom_range(0, 1)), -1);
            rand_loop_dump(1'b1, 3, 2, 15'h7FFF, 2, 1'b0, -1);
        end

        // Never-looping pc: stays in WATCH without freezing the CPU.
        @(negedge clk);
        sel = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        bad = 0;
        s = 15'($urandom_range(0, 20000));
        for (int k = 0; k < 1000; k++) begin
            pc = s + 15'(k);
            if (m_hold || m_valid || m_sel || !m_busy) bad++;
            @(negedge clk);
        end
        chk("noloop_bad_cycles", bad, 0);
        chk("noloop_still_watch", {m_busy, m_done}, 2'b10);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("final_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
